heart_mover: RTL

HEART_MOVER -- requirements
Module: heart_mover

---
 rtl/heart_mover.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/heart_mover.sv
// Heart sprite mover: queues WASD/r keys from the UART, applies at most one move per
// animation frame inside the fighting box, and echoes each applied key back to the UART.
module heart_mover #(
  parameter int F_WIDTH  = 150,
  parameter int F_HEIGHT = 150,
  parameter int FX       = 245,
  parameter int FY       = 230,
  parameter int R        = 5,
  parameter int C_X      = 5,
  parameter int C_Y      = 5,
  parameter int VELOCITY = 5,
  parameter int DEPTH    = 4,
  parameter int CLAMP    = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ani_stb,
  input  logic        i_animate,
  input  logic        i_rx_receive,
  input  logic [7:0]  i_rx_data,
  input  logic        i_tx_busy,
  output logic [15:0] o_cx,
  output logic [15:0] o_cy,
  output logic [15:0] o_r,
  output logic        o_tx_transmit,
  output logic [7:0]  o_tx_data,
  output logic        o_full,
  output logic [7:0]  o_drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic signed [16:0] XMIN = 17'(FX + R);
  localparam logic signed [16:0] XMAX = 17'(FX + F_WIDTH - R);
  localparam logic signed [16:0] YMIN = 17'(FY + R);
  localparam logic signed [16:0] YMAX = 17'(FY + F_HEIGHT - R);
  localparam logic signed [16:0] VEL  = 17'(VELOCITY);
  localparam logic [15:0] HOME_X = 16'(FX + C_X);
  localparam logic [15:0] HOME_Y = 16'(FY + C_Y);

  localparam logic [7:0] KEY_UP    = 8'h77;
  localparam logic [7:0] KEY_LEFT  = 8'h61;
  localparam logic [7:0] KEY_DOWN  = 8'h73;
  localparam logic [7:0] KEY_RIGHT = 8'h64;
  localparam logic [7:0] KEY_HOME  = 8'h72;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SEND
  } echo_state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_cx;
  logic [15:0]   r_cy;
  logic [7:0]    r_tx_data;
  logic [7:0]    r_drop_cnt;
  echo_state_t   r_state;
  echo_state_t   w_state_next;

  logic        w_valid_key;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic [7:0]  w_key;
  logic [15:0] w_cx_next;
  logic [15:0] w_cy_next;

  assign w_valid_key = i_rx_data inside {KEY_UP, KEY_LEFT, KEY_DOWN, KEY_RIGHT, KEY_HOME};
  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign w_pop       = i_ani_stb & i_animate & ~w_empty & (r_state == S_IDLE);
  // A full queue still accepts a key when the same cycle frees a slot.
  assign w_push      = i_rx_receive & w_valid_key & (~w_full | w_pop);
  assign w_drop      = i_rx_receive & w_valid_key & w_full & ~w_pop;
  assign w_key       = r_mem[r_rd_ptr];

  // NOTE: queue storage is deliberately not reset; the count and pointers alone mark valid entries.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_rx_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // Signed 17-bit candidate so a step below zero never wraps into a large positive value.
  function automatic logic [15:0] f_step(input logic [15:0] cur,
                                         input logic signed [16:0] delta,
                                         input logic signed [16:0] lo,
                                         input logic signed [16:0] hi);
    logic signed [16:0] cand;
    cand = $signed({1'b0, cur}) + delta;
    if (cand < lo)      f_step = (CLAMP != 0) ? lo[15:0] : cur;
    else if (cand > hi) f_step = (CLAMP != 0) ? hi[15:0] : cur;
    else                f_step = cand[15:0];
  endfunction

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_cx_next = r_cx;
    w_cy_next = r_cy;
    case (w_key)
      KEY_LEFT:  w_cx_next = f_step(r_cx, -VEL, XMIN, XMAX);
      KEY_RIGHT: w_cx_next = f_step(r_cx,  VEL, XMIN, XMAX);
      KEY_UP:    w_cy_next = f_step(r_cy, -VEL, YMIN, YMAX);
      KEY_DOWN:  w_cy_next = f_step(r_cy,  VEL, YMIN, YMAX);
      KEY_HOME: begin
        w_cx_next = HOME_X;
        w_cy_next = HOME_Y;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cx      <= HOME_X;
      r_cy      <= HOME_Y;
      r_tx_data <= '0;
    end else if (w_pop) begin
      r_cx      <= w_cx_next;
      r_cy      <= w_cy_next;
      r_tx_data <= w_key;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    o_tx_transmit = 1'b0;
    case (r_state)
      S_IDLE: if (w_pop) w_state_next = S_WAIT;
      S_WAIT: if (!i_tx_busy) w_state_next = S_SEND;
      S_SEND: begin
        o_tx_transmit = 1'b1;
        w_state_next  = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_cx       = r_cx;
  assign o_cy       = r_cy;
  assign o_r        = 16'(R);
  assign o_tx_data  = r_tx_data;
  assign o_full     = w_full;
  assign o_drop_cnt = r_drop_cnt;

endmodule
